// File: rtl/riscv_debug_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module  : riscv_debug_ctrl_if
// Brief   : Debug requests, breakpoint programming, write-back trace and
//           core-stall signals between the debug host and riscv_debug_ctrl.
// Revision: 1.0
// =============================================================================
interface riscv_debug_ctrl_if #(
   parameter int PC_W        = 9,
   parameter int NUM_BP      = 4,
   parameter int TRACE_DEPTH = 8
);
   localparam int c_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
   localparam int c_CNT_W = $clog2(TRACE_DEPTH) + 1;

   logic                dbg_halt_req;
   logic                dbg_resume_req;
   logic                dbg_step_req;
   logic                bp_wr_en;
   logic [c_IDX_W-1:0]  bp_wr_idx;
   logic [PC_W-1:0]     bp_wr_addr;
   logic [NUM_BP-1:0]   bp_enable;
   logic [PC_W-1:0]     fetch_pc;
   logic                wb_valid;
   logic [PC_W-1:0]     wb_pc;
   logic [6:0]          wb_opcode;
   logic                trace_clear;
   logic                trace_ready;
   logic                core_stall;
   logic                halted;
   logic [NUM_BP-1:0]   bp_hit;
   logic                trace_valid;
   logic [PC_W+6:0]     trace_data;
   logic [c_CNT_W-1:0]  trace_count;
   logic                trace_overflow;

   modport master (
      output dbg_halt_req, dbg_resume_req, dbg_step_req,
      output bp_wr_en, bp_wr_idx, bp_wr_addr, bp_enable, fetch_pc,
      output wb_valid, wb_pc, wb_opcode, trace_clear, trace_ready,
      input  core_stall, halted, bp_hit,
      input  trace_valid, trace_data, trace_count, trace_overflow
   );

   modport slave (
      input  dbg_halt_req, dbg_resume_req, dbg_step_req,
      input  bp_wr_en, bp_wr_idx, bp_wr_addr, bp_enable, fetch_pc,
      input  wb_valid, wb_pc, wb_opcode, trace_clear, trace_ready,
      output core_stall, halted, bp_hit,
      output trace_valid, trace_data, trace_count, trace_overflow
   );
endinterface
`default_nettype wire

// File: rtl/riscv_debug_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : riscv_debug_ctrl
// Brief   : Halt/run/single-step control, PC breakpoints and write-back trace
//           FIFO; core_stall gates the core clock.
// Revision: 1.0
// =============================================================================
module riscv_debug_ctrl #(
   parameter int PC_W        = 9,
   parameter int NUM_BP      = 4,
   parameter int TRACE_DEPTH = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   riscv_debug_ctrl_if.slave  dbg
);
   localparam int c_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
   localparam int c_PTR_W = $clog2(TRACE_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam int c_ENT_W = PC_W + 7;

   localparam logic [1:0] c_S_RUN  = 2'd0;
   localparam logic [1:0] c_S_HALT = 2'd1;
   localparam logic [1:0] c_S_STEP = 2'd2;

   logic [1:0]          r_state;
   logic [1:0]          w_state_nxt;
   logic                r_skip;
   logic [PC_W-1:0]     r_bp_reg [NUM_BP];
   logic [NUM_BP-1:0]   r_bp_hit;
   logic [NUM_BP-1:0]   w_match_vec;
   logic                w_match;
   logic                w_resume;

   logic [c_ENT_W-1:0]  r_mem [TRACE_DEPTH];
   logic [c_PTR_W-1:0]  r_wr_ptr;
   logic [c_PTR_W-1:0]  r_rd_ptr;
   logic [c_CNT_W-1:0]  r_count;
   logic                r_overflow;
   logic                w_push;
   logic                w_pop;
   logic                w_valid;
   logic                w_full;
   logic                w_drop;

   // ---------------------------------------------------------------- breakpoints
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_BP; i++) r_bp_reg[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (dbg.bp_wr_en && (dbg.bp_wr_idx == c_IDX_W'(i)))
               r_bp_reg[i] <= dbg.bp_wr_addr;
         end
      end
   end

   generate
      for (genvar i = 0; i < NUM_BP; i++) begin : g_bp_match
         assign w_match_vec[i] = dbg.bp_enable[i] && (r_bp_reg[i] == dbg.fetch_pc);
      end
   endgenerate

   // skip lets the core fetch past the breakpoint PC it just resumed from
   assign w_match  = (|w_match_vec) && !r_skip;
   assign w_resume = (r_state == c_S_HALT) && dbg.dbg_resume_req;

   // ---------------------------------------------------------------- run control FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= c_S_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_S_RUN: begin
            if (dbg.dbg_halt_req || w_match) w_state_nxt = c_S_HALT;
         end
         c_S_HALT: begin
            if (dbg.dbg_resume_req)    w_state_nxt = c_S_RUN;
            else if (dbg.dbg_step_req) w_state_nxt = c_S_STEP;
         end
         c_S_STEP: w_state_nxt = c_S_HALT;
         default:  w_state_nxt = c_S_RUN;
      endcase
   end

   always_comb begin
      dbg.core_stall = (r_state == c_S_HALT);
      dbg.halted     = (r_state == c_S_HALT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_skip   <= 1'b0;
         r_bp_hit <= '0;
      end else begin
         r_skip <= w_resume;
         if (w_resume)
            r_bp_hit <= '0;
         else if ((r_state == c_S_RUN) && w_match)
            r_bp_hit <= r_bp_hit | w_match_vec;
      end
   end

   assign dbg.bp_hit = r_bp_hit;

   // ---------------------------------------------------------------- trace FIFO
   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == c_CNT_W'(TRACE_DEPTH));
   assign w_push  = dbg.wb_valid && (r_state != c_S_HALT);
   assign w_pop   = w_valid && dbg.trace_ready;
   // a push into a full FIFO with no pop overwrites the oldest slot
   assign w_drop  = w_full && w_push && !w_pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < TRACE_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_push && !dbg.trace_clear) begin
         r_mem[r_wr_ptr] <= {dbg.wb_pc, dbg.wb_opcode};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (dbg.trace_clear) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push)          r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         if (w_pop || w_drop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         if (w_drop)          r_overflow <= 1'b1;
         if (w_push && !w_pop && !w_full)
            r_count <= r_count + c_CNT_W'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - c_CNT_W'(1);
      end
   end

   assign dbg.trace_valid    = w_valid;
   assign dbg.trace_data     = r_mem[r_rd_ptr];
   assign dbg.trace_count    = r_count;
   assign dbg.trace_overflow = r_overflow;

endmodule
`default_nettype wire
